// File: rtl/fall_spawner.sv
// Falling-block generator: spawns one block at an LFSR-chosen x/colour, moves it down on
// divider ticks, and retires it on catch or miss. Optional macro SPEEDUP_EN scales speed by catches.
module fall_spawner #(
  parameter int TICK_DIV    = 18,
  parameter int X_MIN       = 60,
  parameter int SPAWN_Y     = 0,
  parameter int FLOOR_Y     = 470,
  parameter int OFFSCREEN_Y = 1000,
  parameter int SPAWN_DELAY = 8,
  parameter int MAX_MISSES  = 3,
  parameter int FALL_STEP   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       collision,
  output logic [9:0] fall_x,
  output logic [9:0] fall_y,
  output logic [1:0] fall_color,
  output logic       active,
  output logic       missed,
  output logic [7:0] catches,
  output logic       game_over,
  output logic [1:0] state_dbg
);

  // Handshake note: collision is a level qualified only in FALL; no valid/ready pairs here.
  localparam int DW = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY) : 1;
  localparam int MW = $clog2(MAX_MISSES + 1);

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    FALL = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t              state;
  logic [TICK_DIV-1:0] divider;
  logic [DW-1:0]       delay_cnt;
  logic [MW-1:0]       miss_cnt;
  logic [9:0]          lfsr;
  logic [9:0]          step;
  logic                tick;

  assign tick      = (divider == '0) && !pause;
  assign state_dbg = state;

`ifdef SPEEDUP_EN
  logic [7:0] step_raw;
  always_comb begin
    step_raw = 8'(FALL_STEP) + (catches >> 2);
    step     = (step_raw > 8'd8) ? 10'd8 : {2'b00, step_raw};
  end
`else
  always_comb begin
    step = 10'(FALL_STEP);
  end
`endif

  // The LFSR free-runs every cycle, pause included, so spawn positions depend on play timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 10'h2A5;
    end else begin
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divider <= '0;
    end else if (!pause) begin
      divider <= divider + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT;
      fall_x     <= 10'd0;
      fall_y     <= 10'(OFFSCREEN_Y);
      fall_color <= 2'd0;
      active     <= 1'b0;
      missed     <= 1'b0;
      catches    <= 8'd0;
      game_over  <= 1'b0;
      miss_cnt   <= '0;
      delay_cnt  <= '0;
    end else begin
      missed <= 1'b0;
      case (state)
        WAIT: begin
          fall_y <= 10'(OFFSCREEN_Y);
          active <= 1'b0;
          if (tick) begin
            if (delay_cnt == DW'(SPAWN_DELAY - 1)) begin
              state      <= FALL;
              active     <= 1'b1;
              fall_x     <= 10'(X_MIN) + {1'b0, lfsr[8:0]};
              fall_color <= (lfsr[1:0] == 2'd0) ? 2'd1 : lfsr[1:0];
              fall_y     <= 10'(SPAWN_Y);
              delay_cnt  <= '0;
            end else begin
              delay_cnt <= delay_cnt + 1'b1;
            end
          end
        end
        FALL: begin
          // Catch beats the floor test so a simultaneous hit is never scored as a miss.
          if (collision) begin
            state  <= WAIT;
            active <= 1'b0;
            fall_y <= 10'(OFFSCREEN_Y);
            if (catches != 8'hFF) catches <= catches + 8'd1;
          end else if (!pause && (fall_y >= 10'(FLOOR_Y))) begin
            active   <= 1'b0;
            missed   <= 1'b1;
            fall_y   <= 10'(OFFSCREEN_Y);
            miss_cnt <= miss_cnt + 1'b1;
            if (miss_cnt == MW'(MAX_MISSES - 1)) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else if (tick) begin
            fall_y <= fall_y + step;
          end
        end
        OVER: begin
          game_over <= 1'b1;
          active    <= 1'b0;
          fall_y    <= 10'(OFFSCREEN_Y);
        end
        default: begin
          state  <= WAIT;
          active <= 1'b0;
          fall_y <= 10'(OFFSCREEN_Y);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fall_spawner.sv
// Bench for fall_spawner with a fast tick divider: spawn timing/position, descent, miss,
// catch, pause, game over and reset, with a catch-count scoreboard and an LFSR model.
module tb_fall_spawner;

  logic       clk;
  logic       rst;
  logic       pause;
  logic       collision;
  logic [9:0] fall_x;
  logic [9:0] fall_y;
  logic [1:0] fall_color;
  logic       active;
  logic       missed;
  logic [7:0] catches;
  logic       game_over;
  logic [1:0] state_dbg;

  fall_spawner #(.TICK_DIV(2), .SPAWN_DELAY(8)) dut (
    .clk(clk), .rst(rst), .pause(pause), .collision(collision),
    .fall_x(fall_x), .fall_y(fall_y), .fall_color(fall_color),
    .active(active), .missed(missed), .catches(catches),
    .game_over(game_over), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference LFSR (x^10+x^7+1); m_prev is the value the DUT saw before the latest edge.
  logic [9:0] m_lfsr, m_prev;
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (rst) m_lfsr <= 10'h2A5;
    else     m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  // Miss pulse monitor: total pulses and longest run of consecutive high samples.
  int miss_pulses = 0;
  int miss_run = 0;
  int miss_run_max = 0;
  always @(negedge clk) begin
    if (missed) begin
      if (miss_run == 0) miss_pulses++;
      miss_run++;
      if (miss_run > miss_run_max) miss_run_max = miss_run;
    end else begin
      miss_run = 0;
    end
  end

  // driver tasks
  task automatic wait_spawn(input string tag, output int n);
    n = 0;
    while (!active && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(active), 32'd1);
  endtask

  task automatic check_spawn(input string tag);
    logic [9:0] ex;
    logic [1:0] ec;
    ex = 10'd60 + {1'b0, m_prev[8:0]};
    ec = (m_prev[1:0] == 2'd0) ? 2'd1 : m_prev[1:0];
    check({tag, "_x"}, 32'(fall_x), 32'(ex));
    check({tag, "_color"}, 32'(fall_color), 32'(ec));
    check({tag, "_y"}, 32'(fall_y), 32'd0);
    check({tag, "_color_range"}, 32'(fall_color != 2'd0), 32'd1);
    check({tag, "_x_range"}, 32'(fall_x >= 10'd60 && fall_x <= 10'd571), 32'd1);
  endtask

  task automatic wait_y(input string tag, input logic [9:0] y);
    int n;
    n = 0;
    while (fall_y != y && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reach"}, 32'(fall_y), 32'(y));
  endtask

  task automatic wait_miss(input string tag);
    int n;
    n = 0;
    while (!missed && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pulse"}, 32'(missed), 32'd1);
    check({tag, "_parked_y"}, 32'(fall_y), 32'd1000);
    check({tag, "_inactive"}, 32'(active), 32'd0);
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(missed), 32'd0);
  endtask

  task automatic sb_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(catches), 32'(e));
    end
  endtask

  logic [9:0] first_x;
  logic [9:0] y0;
  int n;
  int mp;

  initial begin
    rst = 1'b1;
    pause = 1'b0;
    collision = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_y", 32'(fall_y), 32'd1000);
    check("rst_x", 32'(fall_x), 32'd0);
    check("rst_color", 32'(fall_color), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_missed", 32'(missed), 32'd0);
    check("rst_catches", 32'(catches), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    rst = 1'b0;

    // 8 ticks 4 clocks apart, the first on the first edge after reset: spawn on edge 29.
    wait_spawn("spawn1", n);
    check("spawn1_latency", 32'(n), 32'd29);
    check_spawn("spawn1");
    first_x = fall_x;

    for (int i = 1; i <= 5; i++) begin
      repeat (4) @(negedge clk);
      check("descent_y", 32'(fall_y), 32'(2 * i));
    end

    wait_miss("miss1");
    check("miss1_width", 32'(miss_run_max), 32'd1);
    check("miss1_over", 32'(game_over), 32'd0);

    // Catch with collision held 3 cycles at y=100.
    wait_spawn("spawn2", n);
    check_spawn("spawn2");
    wait_y("catch1", 10'd100);
    mp = miss_pulses;
    collision = 1'b1;
    exp_q.push_back(catches + 8'd1);
    @(negedge clk);
    check("catch1_parked_y", 32'(fall_y), 32'd1000);
    check("catch1_inactive", 32'(active), 32'd0);
    repeat (2) @(negedge clk);
    collision = 1'b0;
    sb_check("catch1_count");
    check("catch1_no_miss", 32'(miss_pulses), 32'(mp));

    // Pause mid-fall holds y; a collision under pause still catches; WAIT stays frozen.
    wait_spawn("spawn3", n);
    wait_y("pause", 10'd20);
    pause = 1'b1;
    y0 = fall_y;
    repeat (50) @(negedge clk);
    check("pause_hold_y", 32'(fall_y), 32'(y0));
    check("pause_active", 32'(active), 32'd1);
    collision = 1'b1;
    exp_q.push_back(catches + 8'd1);
    @(negedge clk);
    collision = 1'b0;
    sb_check("pause_catch_count");
    check("pause_catch_y", 32'(fall_y), 32'd1000);
    repeat (50) @(negedge clk);
    check("pause_wait_frozen", 32'(active), 32'd0);
    pause = 1'b0;

    // Collision in the same cycle the block sits at the floor: catch, no miss.
    wait_spawn("spawn4", n);
    check_spawn("spawn4");
    wait_y("floor", 10'd470);
    mp = miss_pulses;
    collision = 1'b1;
    exp_q.push_back(catches + 8'd1);
    @(negedge clk);
    collision = 1'b0;
    sb_check("floor_catch_count");
    check("floor_no_miss", 32'(miss_pulses), 32'(mp));
    check("floor_parked_y", 32'(fall_y), 32'd1000);

    // Miss count was 1; the next miss must not end the game, the one after must.
    wait_spawn("spawn5", n);
    wait_miss("miss2");
    check("miss2_over", 32'(game_over), 32'd0);
    wait_spawn("spawn6", n);
    wait_miss("miss3");
    check("miss3_over", 32'(game_over), 32'd1);

    collision = 1'b1;
    exp_q.push_back(catches);
    repeat (3) @(negedge clk);
    collision = 1'b0;
    sb_check("over_collision_ignored");
    repeat (100) @(negedge clk);
    check("over_inactive", 32'(active), 32'd0);
    check("over_y", 32'(fall_y), 32'd1000);
    check("over_sticky", 32'(game_over), 32'd1);

    rst = 1'b1;
    @(negedge clk);
    check("rerst_over", 32'(game_over), 32'd0);
    check("rerst_catches", 32'(catches), 32'd0);
    check("rerst_y", 32'(fall_y), 32'd1000);
    rst = 1'b0;
    wait_spawn("respawn", n);
    check("respawn_latency", 32'(n), 32'd29);
    check_spawn("respawn");
    check("respawn_reseed_x", 32'(fall_x), 32'(first_x));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
